// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Shared Morse definitions for the receiver and the transmitter
//               lookup: the eight 11-bit letter patterns (A..H), the frame
//               length, the default element period and the receiver FSM
//               state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    localparam int FRAME_LEN          = 11;
    localparam int DEFAULT_BIT_PERIOD = 250;

    // Element-level patterns, first transmitted element in bit 10.
    localparam logic [FRAME_LEN-1:0] PAT_A = 11'b10111000000;
    localparam logic [FRAME_LEN-1:0] PAT_B = 11'b11101010100;
    localparam logic [FRAME_LEN-1:0] PAT_C = 11'b11101011101;
    localparam logic [FRAME_LEN-1:0] PAT_D = 11'b11101010000;
    localparam logic [FRAME_LEN-1:0] PAT_E = 11'b10000000000;
    localparam logic [FRAME_LEN-1:0] PAT_F = 11'b10101110100;
    localparam logic [FRAME_LEN-1:0] PAT_G = 11'b11101110100;
    localparam logic [FRAME_LEN-1:0] PAT_H = 11'b10101010000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CENTER = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DECODE = 2'd3
    } state_t;

    // Letter code -> pattern, used by the transmitter lookup.
    function automatic logic [FRAME_LEN-1:0] pattern_of(input logic [2:0] code);
        case (code)
            3'd0:    pattern_of = PAT_A;
            3'd1:    pattern_of = PAT_B;
            3'd2:    pattern_of = PAT_C;
            3'd3:    pattern_of = PAT_D;
            3'd4:    pattern_of = PAT_E;
            3'd5:    pattern_of = PAT_F;
            3'd6:    pattern_of = PAT_G;
            default: pattern_of = PAT_H;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_match.sv
`default_nettype none
// ============================================================================
// Module      : morse_match
// Description : Combinational comparison of a captured 11-bit frame against
//               the eight letter patterns.
// Ports       : word  in  [10:0] captured frame, first element in bit 10
//               code  out [2:0]  matching letter code (000=A .. 111=H)
//               hit   out        1 when word equals one of the patterns
// Revision    : 1.0 - initial release
// ============================================================================
module morse_match
    import morse_pkg::*;
(
    input  logic [FRAME_LEN-1:0] word,
    output logic [2:0]           code,
    output logic                 hit
);

    always_comb begin
        code = 3'd0;
        hit  = 1'b1;
        case (word)
            PAT_A:   code = 3'd0;
            PAT_B:   code = 3'd1;
            PAT_C:   code = 3'd2;
            PAT_D:   code = 3'd3;
            PAT_E:   code = 3'd4;
            PAT_F:   code = 3'd5;
            PAT_G:   code = 3'd6;
            PAT_H:   code = 3'd7;
            default: hit  = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/morse_rx.sv
`default_nettype none
// ============================================================================
// Module      : morse_rx
// Description : Morse receiver. Synchronises the key line, detects the start
//               edge, samples 11 elements at their centres and decodes them
//               into a letter code A..H.
// Ports       : ClockIn      in       sole clock, rising edge
//               Reset        in       asynchronous, active-high
//               DotDashIn    in       raw key line (1 = key down)
//               Letter       out [2:0] last decoded letter, held between pulses
//               LetterValid  out      1-cycle pulse, Letter updated with it
//               CodeError    out      1-cycle pulse, frame matched nothing
//               Busy         out      high while a frame is timed or decoded
// Revision    : 1.0 - initial release
// ============================================================================
module morse_rx
    import morse_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD   // even, 4..255
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       DotDashIn,
    output logic [2:0] Letter,
    output logic       LetterValid,
    output logic       CodeError,
    output logic       Busy
);

    // Count of BIT_PERIOD/2-1 lands the first sample exactly half an
    // element after the detected edge; later samples are a full period apart.
    localparam logic [7:0] HALF_LOAD = 8'(BIT_PERIOD / 2 - 1);
    localparam logic [7:0] FULL_LOAD = 8'(BIT_PERIOD - 1);
    localparam logic [3:0] LAST_BIT  = 4'(FRAME_LEN - 1);

    logic                 sync1_q, s_q, s_prev_q;
    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [3:0]           nbits_q, nbits_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [2:0]           letter_q, letter_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 s_rise;
    logic [2:0]           match_code;
    logic                 match_hit;

    assign s_rise = s_q & ~s_prev_q;

    // Synchroniser and edge-detect history.
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= DotDashIn;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
        end
    end

    // State register.
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (s_rise) begin
                    state_d = ST_CENTER;
                    cnt_d   = HALF_LOAD;
                end
            end
            ST_CENTER: begin
                if (cnt_q == 8'd0) begin
                    if (s_q) begin
                        shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b1};
                        nbits_d = 4'd1;
                        cnt_d   = FULL_LOAD;
                        state_d = ST_SAMPLE;
                    end else begin
                        // Line dropped before mid-element: treat as a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == 8'd0) begin
                    shreg_d = {shreg_q[FRAME_LEN-2:0], s_q};
                    nbits_d = nbits_q + 4'd1;
                    cnt_d   = FULL_LOAD;
                    if (nbits_q == LAST_BIT) begin
                        state_d = ST_DECODE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode; pulses are registered so they appear the cycle after
    // DECODE, by which time the FSM is already back in IDLE.
    always_comb begin
        Busy     = (state_q != ST_IDLE);
        valid_d  = (state_q == ST_DECODE) &&  match_hit;
        err_d    = (state_q == ST_DECODE) && !match_hit;
        letter_d = valid_d ? match_code : letter_q;
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= 8'd0;
            nbits_q  <= 4'd0;
            shreg_q  <= '0;
            letter_q <= 3'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            nbits_q  <= nbits_d;
            shreg_q  <= shreg_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    morse_match u_match (
        .word (shreg_q),
        .code (match_code),
        .hit  (match_hit)
    );

    assign Letter      = letter_q;
    assign LetterValid = valid_q;
    assign CodeError   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_rx
// Description : Self-checking bench for morse_rx at BIT_PERIOD=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_rx;

    localparam int P = 4;

    logic       clk;
    logic       rst;
    logic       din;
    logic [2:0] letter;
    logic       valid;
    logic       cerr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [2:0] mon_letter = 3'd0;
    logic prev_pulse = 1'b0;

    typedef struct {
        logic [10:0] pat;
        int          exp_v;
        int          exp_e;
        logic [2:0]  exp_l;
    } vec_t;

    vec_t vecs[9];

    morse_rx #(.BIT_PERIOD(P)) dut (
        .ClockIn     (clk),
        .Reset       (rst),
        .DotDashIn   (din),
        .Letter      (letter),
        .LetterValid (valid),
        .CodeError   (cerr),
        .Busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pulse monitor: counts pulses and checks the pulse rules.
    always @(negedge clk) begin
        if (valid || cerr) begin
            checks++;
            if (valid && cerr) begin
                errors++;
                $display("FAIL pulse_overlap valid=%0b err=%0b", valid, cerr);
            end else if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_back_to_back valid=%0b err=%0b", valid, cerr);
            end
        end
        prev_pulse = valid | cerr;
        if (valid) begin
            n_valid++;
            mon_letter = letter;
        end
        if (cerr) n_err++;
    end

    // Drive the first nb elements of pat, P cycles each, from a negedge.
    task automatic send_bits(input logic [10:0] pat, input int nb);
        for (int i = 0; i < nb; i++) begin
            din = pat[10 - i];
            repeat (P) @(negedge clk);
        end
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bv, be;

        vecs[0] = '{11'b10111000000, 1, 0, 3'd0};
        vecs[1] = '{11'b11101010100, 1, 0, 3'd1};
        vecs[2] = '{11'b11101011101, 1, 0, 3'd2};
        vecs[3] = '{11'b11101010000, 1, 0, 3'd3};
        vecs[4] = '{11'b10000000000, 1, 0, 3'd4};
        vecs[5] = '{11'b10101110100, 1, 0, 3'd5};
        vecs[6] = '{11'b11101110100, 1, 0, 3'd6};
        vecs[7] = '{11'b10101010000, 1, 0, 3'd7};
        vecs[8] = '{11'b11111111111, 0, 1, 3'd7};   // no match, Letter holds H

        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_letter", int'(letter), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(cerr), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single A frame with exact pulse timing: input changes before edge
        // t0, edge detected at E=t0+2, pulse registered at E+2+40+1.
        bv = n_valid; be = n_err;
        fork
            send_bits(11'b10111000000, 11);
            begin
                repeat (45) @(posedge clk);
                #1 check("a_early_valid", int'(valid), 0);
                @(posedge clk);
                #1 check("a_valid_time", int'(valid), 1);
                check("a_letter", int'(letter), 0);
                check("a_busy_after", int'(busy), 0);
            end
        join
        gap(12);
        check("a_pulse_count", n_valid - bv, 1);
        check("a_err_count", n_err - be, 0);

        // Back-to-back letters and a non-matching frame.
        for (int i = 0; i < 9; i++) begin
            bv = n_valid; be = n_err;
            send_bits(vecs[i].pat, 11);
            gap(12);
            check($sformatf("vec%0d_valid_cnt", i), n_valid - bv, vecs[i].exp_v);
            check($sformatf("vec%0d_err_cnt", i), n_err - be, vecs[i].exp_e);
            check($sformatf("vec%0d_letter", i), int'(letter), int'(vecs[i].exp_l));
            if (vecs[i].exp_v == 1)
                check($sformatf("vec%0d_pulse_letter", i), int'(mon_letter),
                      int'(vecs[i].exp_l));
        end

        // One-cycle glitch: Busy rises at E, falls after the centre sample.
        bv = n_valid; be = n_err;
        din = 1'b1;
        @(negedge clk);
        din = 1'b0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 check("glitch_busy_high", int'(busy), 1);
                repeat (2) @(posedge clk);
                #1 check("glitch_busy_low", int'(busy), 0);
            end
        join
        gap(10);
        check("glitch_valid_cnt", n_valid - bv, 0);
        check("glitch_err_cnt", n_err - be, 0);

        // C then line held high: no retrigger.
        bv = n_valid; be = n_err;
        send_bits(11'b11101011101, 11);
        din = 1'b1;
        repeat (60) @(negedge clk);
        check("chold_busy", int'(busy), 0);
        gap(12);
        check("chold_valid_cnt", n_valid - bv, 1);
        check("chold_err_cnt", n_err - be, 0);
        check("chold_letter", int'(letter), 2);

        // Reset in the middle of B, then E.
        bv = n_valid; be = n_err;
        send_bits(11'b11101010100, 4);
        rst = 1'b1;
        din = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_letter", int'(letter), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gap(60);
        check("midrst_no_pulse", (n_valid - bv) + (n_err - be), 0);
        bv = n_valid; be = n_err;
        send_bits(11'b10000000000, 11);
        gap(12);
        check("after_rst_valid_cnt", n_valid - bv, 1);
        check("after_rst_err_cnt", n_err - be, 0);
        check("after_rst_letter", int'(letter), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
